// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer driving an up/down counter between latched lo/hi bounds.
// Optional freeze input enabled by defining COUNTER_SWEEP_PAUSE_EN.
module counter_sweep_ctrl #(
  parameter int WIDTH = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [REP_W-1:0] reps,
`ifdef COUNTER_SWEEP_PAUSE_EN
  input  logic             pause,
`endif
  output logic [WIDTH-1:0] count,
  output logic             ud,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // state  | meaning
  // IDLE   | waiting for an accepted start
  // UP     | counting toward the latched ceiling
  // DOWN   | counting toward the latched floor, one repetition ends at the floor
  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_t;

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [REP_W-1:0] ONE_R = REP_W'(1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic [WIDTH-1:0] r_lo, w_lo_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [REP_W-1:0] r_rem, w_rem_nxt;
  logic             r_ud, w_ud_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;

  logic             w_pause;
  logic             w_start_ok;
  logic             w_at_top;
  logic             w_at_bottom;
  logic             w_last_rep;

`ifdef COUNTER_SWEEP_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_start_ok  = (lo < hi) && (reps != '0);
  assign w_at_top    = (r_count == (r_hi - ONE_W));
  assign w_at_bottom = (r_count == (r_lo + ONE_W));
  assign w_last_rep  = (r_rem == ONE_R);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_rem   <= '0;
      r_ud    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_lo    <= w_lo_nxt;
      r_hi    <= w_hi_nxt;
      r_rem   <= w_rem_nxt;
      r_ud    <= w_ud_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && w_start_ok) w_state_nxt = S_UP;
      end
      S_UP: begin
        if (!w_pause && w_at_top) w_state_nxt = S_DOWN;
      end
      S_DOWN: begin
        if (!w_pause && w_at_bottom) w_state_nxt = w_last_rep ? S_IDLE : S_UP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pulses default low so done/err last exactly one cycle.
  always_comb begin
    w_count_nxt = r_count;
    w_lo_nxt    = r_lo;
    w_hi_nxt    = r_hi;
    w_rem_nxt   = r_rem;
    w_ud_nxt    = r_ud;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_start_ok) begin
            w_lo_nxt    = lo;
            w_hi_nxt    = hi;
            w_rem_nxt   = reps;
            w_count_nxt = lo;
            w_ud_nxt    = 1'b1;
            w_busy_nxt  = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_UP: begin
        if (!w_pause) begin
          w_count_nxt = r_count + ONE_W;
          if (w_at_top) w_ud_nxt = 1'b0;
        end
      end
      S_DOWN: begin
        if (!w_pause) begin
          w_count_nxt = r_count - ONE_W;
          if (w_at_bottom) begin
            w_rem_nxt = r_rem - ONE_R;
            w_ud_nxt  = 1'b1;
            if (w_last_rep) begin
              w_busy_nxt = 1'b0;
              w_done_nxt = 1'b1;
            end
          end
        end
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  assign count = r_count;
  assign ud    = r_ud;
  assign busy  = r_busy;
  assign done  = r_done;
  assign err   = r_err;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: edge-indexed triangle model plus directed literal checks.
// The pause scenario is exercised only when COUNTER_SWEEP_PAUSE_EN is defined.
module tb_counter_sweep_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [3:0] reps;
  logic       pause_tb;
  logic [3:0] count;
  logic       ud;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks;
  int n_fail;

  counter_sweep_ctrl #(.WIDTH(4), .REP_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .lo    (lo),
    .hi    (hi),
    .reps  (reps),
`ifdef COUNTER_SWEEP_PAUSE_EN
    .pause (pause_tb),
`endif
    .count (count),
    .ud    (ud),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: position j along the accepted sweep, counted in edges since acceptance.
  bit m_valid;
  bit m_busy;
  bit m_ud;
  bit m_done;
  bit m_err;
  int m_cnt;
  int m_lo;
  int m_d;
  int m_r;
  int m_j;

  always @(posedge clk) begin
    int p;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (!rst) begin
      m_valid = 1'b1;
      m_busy  = 1'b0;
      m_cnt   = 0;
      m_ud    = 1'b1;
    end else if (!m_busy) begin
      if (start) begin
        if (lo >= hi || reps == 0) begin
          m_err = 1'b1;
        end else begin
          m_busy = 1'b1;
          m_lo   = int'(lo);
          m_d    = int'(hi) - int'(lo);
          m_r    = int'(reps);
          m_j    = 0;
          m_cnt  = m_lo;
          m_ud   = 1'b1;
        end
      end
    end else if (!pause_tb) begin
      m_j  = m_j + 1;
      p    = m_j % (2 * m_d);
      m_cnt = m_lo + ((p <= m_d) ? p : (2 * m_d - p));
      m_ud  = (p < m_d);
      if (m_j == 2 * m_d * m_r) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cmp_count", count, m_cnt);
      chk("cmp_ud",    ud,    m_ud);
      chk("cmp_busy",  busy,  m_busy);
      chk("cmp_done",  done,  m_done);
      chk("cmp_err",   err,   m_err);
    end
  end

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_timeout", busy, 0);
  endtask

  int e1_cnt[7];
  int e1_ud[7];
  int peaks;
  int done_edge;
  int done_seen;
  int max_cnt;

  initial begin
    e1_cnt = '{2, 3, 4, 5, 4, 3, 2};
    e1_ud  = '{1, 1, 1, 0, 0, 0, 1};
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; start = 1'b0; lo = '0; hi = '0; reps = '0; pause_tb = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_ud",    ud,    1);
    chk("rst_busy",  busy,  0);
    chk("rst_done",  done,  0);
    chk("rst_err",   err,   0);
    rst = 1'b1;
    @(negedge clk);

    // Basic sweep 2..5, one repetition
    lo = 4'd2; hi = 4'd5; reps = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      chk("t1_count", count, e1_cnt[k]);
      chk("t1_ud",    ud,    e1_ud[k]);
      chk("t1_done",  done,  (k == 6) ? 1 : 0);
      chk("t1_busy",  busy,  (k == 6) ? 0 : 1);
    end

    // Rejected starts
    lo = 4'd7; hi = 4'd7; reps = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rej1_err",   err,   1);
    chk("rej1_busy",  busy,  0);
    chk("rej1_count", count, 2);
    @(negedge clk);
    chk("rej1_err_clr", err, 0);
    lo = 4'd3; hi = 4'd9; reps = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rej2_err",   err,   1);
    chk("rej2_busy",  busy,  0);
    chk("rej2_count", count, 2);
    @(negedge clk);
    chk("rej2_err_clr", err, 0);

    // Full range, three reps, start held through done for back-to-back
    lo = 4'd0; hi = 4'd15; reps = 4'd3; start = 1'b1;
    peaks = 0; done_edge = -1;
    for (int e = 0; e <= 91; e++) begin
      @(negedge clk);
      if (count == 4'd15) peaks++;
      if (done && done_edge < 0) done_edge = e;
    end
    chk("t2_peaks",     peaks,     3);
    chk("t2_done_edge", done_edge, 90);
    chk("t2_b2b_count", count,     0);
    chk("t2_b2b_busy",  busy,      1);
    start = 1'b0; lo = 4'd9; hi = 4'd3; reps = 4'd0;
    wait_idle(200);
    @(negedge clk);

    // Reset in the middle of a sweep
    lo = 4'd1; hi = 4'd6; reps = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t4_count", count, 0);
    chk("t4_ud",    ud,    1);
    chk("t4_busy",  busy,  0);
    chk("t4_done",  done,  0);
    rst = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("t4_no_done", done_seen, 0);
    lo = 4'd4; hi = 4'd6; reps = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4_restart_busy",  busy,  1);
    chk("t4_restart_count", count, 4);
    wait_idle(50);
    @(negedge clk);

    // Start with new bounds while busy is ignored
    lo = 4'd1; hi = 4'd3; reps = 4'd2; start = 1'b1;
    @(negedge clk);
    lo = 4'd0; hi = 4'd9; reps = 4'd5;
    max_cnt = 0; done_edge = -1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (e == 5) start = 1'b0;
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (done && done_edge < 0) done_edge = e;
    end
    chk("t5_max",       max_cnt,   3);
    chk("t5_done_edge", done_edge, 8);
    chk("t5_end_count", count,     1);
    @(negedge clk);

`ifdef COUNTER_SWEEP_PAUSE_EN
    lo = 4'd2; hi = 4'd5; reps = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    pause_tb = 1'b1;
    for (int e = 3; e <= 5; e++) begin
      @(negedge clk);
      chk("t6_hold_count", count, 4);
      chk("t6_hold_busy",  busy,  1);
    end
    pause_tb = 1'b0;
    done_edge = -1;
    for (int e = 6; e <= 10; e++) begin
      @(negedge clk);
      if (done && done_edge < 0) done_edge = e;
    end
    chk("t6_done_edge", done_edge, 9);
    pause_tb = 1'b1;
    @(negedge clk);
    pause_tb = 1'b0;
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_sweep_ctrl.md
# counter_sweep_ctrl

Sequencer that owns an up/down counter and drives it through programmable triangle sweeps. A sweep runs up from a low bound to a high bound, then back down, for a requested number of repetitions. It uses a start/busy/done handshake and sits between a control master and any logic that consumes the count and direction.

## Interface
- WIDTH, 4, counter width in bits
- REP_W, 4, width of the repetition-count input
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low
- start  input  1  request a sweep; sampled only when idle
- lo  input  WIDTH  sweep floor, latched on accepted start
- hi  input  WIDTH  sweep ceiling, latched on accepted start
- reps  input  REP_W  number of full up+down sweeps, latched on accepted start
- pause  input  1  freeze sweep; present only with COUNTER_SWEEP_PAUSE_EN
- count  output  WIDTH  current counter value
- ud  output  1  direction of the next step: 1 = up, 0 = down
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse on sweep completion
- err  output  1  one-cycle pulse on a rejected start

## Operation
- States: IDLE, UP, DOWN. An internal repetition counter `rem` is REP_W bits wide.
- Reset (rst=0 at an edge) forces the following, regardless of state:
  - state=IDLE
  - count=0, ud=1, busy=0, done=0, err=0, rem=0
  - An aborted sweep produces no done.
- IDLE with start=1 and (lo>=hi or reps==0):
  - err<=1 for one cycle.
  - State, count and busy are unchanged.
- IDLE with start=1 and lo<hi and reps!=0:
  - Latch lo, hi and reps into rem.
  - count<=lo, ud<=1, busy<=1, state<=UP.
- UP:
  - count<=count+1.
  - If count==hi-1: ud<=0, state<=DOWN.
- DOWN:
  - count<=count-1.
  - If count==lo+1: rem<=rem-1.
    - If rem==1 (last sweep): busy<=0, done<=1, ud<=1, state<=IDLE.
    - Otherwise: ud<=1, state<=UP.
- No dwell at either bound: each value hi and lo appears for exactly one cycle per turn-around.
- count never leaves [lo,hi] while busy, so no wrap-around.
- start is ignored while busy.
- done and err are never asserted together.
- Input values of lo, hi and reps after acceptance have no effect.
- Full range lo=0, hi=2^WIDTH-1 is legal.

## Timing
- Let D=hi-lo and R=reps. The accepting edge is edge 0.
- Edge 0: count=lo, busy=1, ud=1.
- Edge k, for 1<=k<=D: count=lo+k. ud=0 from edge D.
- Each sweep takes 2D cycles.
- Edge 2DR: count=lo, busy=0, done=1.
- Edge 2DR+1: done=0.
- A start held high during the done cycle is accepted at edge 2DR+1, giving back-to-back sweeps with no gap.
- err asserts on the edge after start is sampled and lasts one cycle.

## Configuration
- COUNTER_SWEEP_PAUSE_EN defined:
  - Port pause exists.
  - pause=1 at an edge while in UP or DOWN holds count, ud, state and rem; busy stays 1.
  - Each paused cycle extends the sweep by one cycle.
  - pause has no effect in IDLE.
  - rst overrides pause.
- COUNTER_SWEEP_PAUSE_EN undefined: no pause port; behaviour is as if pause=0.

## Test plan
- lo=2, hi=5, reps=1, start pulsed:
  - count over edges 0..6 = 2,3,4,5,4,3,2.
  - ud=1,1,1,0,0,0,1.
  - done=1 at edge 6 only; busy=0 from edge 6.
- lo=0, hi=15, reps=3:
  - count peaks at 15 three times, never exceeds 15 or wraps.
  - done at edge 90.
  - start held high through the done cycle -> second sweep accepted at edge 91 with count=0.
- Rejected starts:
  - lo=7, hi=7, reps=2 -> err=1 for one cycle, busy=0, count unchanged.
  - lo=3, hi=9, reps=0 -> same response.
- Reset mid-sweep: lo=1, hi=6, reps=2, rst=0 at edge 4 -> count=0, ud=1, busy=0, no done pulse; a new start is accepted afterwards.
- start=1 with different lo and hi while busy -> ignored; sweep completes with the originally latched bounds.
- With COUNTER_SWEEP_PAUSE_EN, lo=2, hi=5, reps=1:
  - pause=1 for 3 cycles starting at edge 2 -> count holds at 4, busy=1.
  - done at edge 9.
